// File: rtl/i2c_bus_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_filter
// Description : SCL/SDA input conditioning for the I2C master. Synchronises
//               both pad inputs, low-pass filters them at a programmable
//               sampling rate, and produces clean levels, SCL edge pulses,
//               START/STOP detect pulses and a bus-busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_filter #(
  parameter int FILT_DEPTH = 3
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_EN,
  input  logic [7:0] I_I2CDFSRR,
  input  logic       I_SCL_PIN,
  input  logic       I_SDA_PIN,
  output logic       O_SCL,
  output logic       O_SDA,
  output logic       O_SCL_RISE,
  output logic       O_SCL_FALL,
  output logic       O_START,
  output logic       O_STOP,
  output logic       O_BUSY
);

  // Sample-window patterns that allow the filtered level to change.
  localparam logic [FILT_DEPTH-1:0] C_ALL_ONES  = {FILT_DEPTH{1'b1}};
  localparam logic [FILT_DEPTH-1:0] C_ALL_ZEROS = {FILT_DEPTH{1'b0}};

  // Two-flop synchronisers (idle bus level is 1).
  logic                  r_scl_meta;
  logic                  r_scl_sync;
  logic                  r_sda_meta;
  logic                  r_sda_sync;

  // Sampling-rate prescaler.
  logic [5:0]            w_dfsr;
  logic [5:0]            r_cnt;
  logic                  w_tick;

  // Sample windows, newest sample in bit 0.
  logic [FILT_DEPTH-1:0] r_scl_smp;
  logic [FILT_DEPTH-1:0] r_sda_smp;

  // Filtered levels and registered event outputs.
  logic                  r_scl;
  logic                  r_sda;
  logic                  r_scl_rise;
  logic                  r_scl_fall;
  logic                  r_start;
  logic                  r_stop;
  logic                  r_busy;

  // Next-state filter values and condition decode.
  logic                  w_scl_nxt;
  logic                  w_sda_nxt;
  logic                  w_start;
  logic                  w_stop;

  // Only the low six bits of the sampling-rate register are meaningful.
  logic                  w_dfsr_unused;

  assign w_dfsr        = I_I2CDFSRR[5:0];
  assign w_dfsr_unused = ^I_I2CDFSRR[7:6];

  // Synchronise the raw pads; this runs even while the block is disabled so
  // that re-enabling starts from a settled view of the bus.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_scl_meta <= I_SCL_PIN;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= I_SDA_PIN;
      r_sda_sync <= r_sda_meta;
    end
  end

  // A greater-or-equal compare means lowering DFSR mid-count takes effect
  // immediately instead of waiting for the counter to wrap.
  assign w_tick = (r_cnt >= w_dfsr);

  // Prescaler: wraps to zero on every tick.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_cnt <= 6'd0;
    end else if (!I_EN) begin
      r_cnt <= 6'd0;
    end else if (w_tick) begin
      r_cnt <= 6'd0;
    end else begin
      r_cnt <= r_cnt + 6'd1;
    end
  end

  // Shift the synchronised levels into the sample windows on each tick.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_scl_smp <= C_ALL_ONES;
      r_sda_smp <= C_ALL_ONES;
    end else if (!I_EN) begin
      r_scl_smp <= C_ALL_ONES;
      r_sda_smp <= C_ALL_ONES;
    end else if (w_tick) begin
      r_scl_smp <= {r_scl_smp[FILT_DEPTH-2:0], r_scl_sync};
      r_sda_smp <= {r_sda_smp[FILT_DEPTH-2:0], r_sda_sync};
    end
  end

  // Filter decision: a level only moves when the whole window agrees; the
  // same next-state values drive the edge and START/STOP decode so that all
  // event pulses line up with the level change that caused them.
  always_comb begin
    w_scl_nxt = r_scl;
    w_sda_nxt = r_sda;
    if (r_scl_smp == C_ALL_ONES) begin
      w_scl_nxt = 1'b1;
    end else if (r_scl_smp == C_ALL_ZEROS) begin
      w_scl_nxt = 1'b0;
    end
    if (r_sda_smp == C_ALL_ONES) begin
      w_sda_nxt = 1'b1;
    end else if (r_sda_smp == C_ALL_ZEROS) begin
      w_sda_nxt = 1'b0;
    end
    // SCL must be high before and after the update; an SCL change in the
    // same update masks the SDA transition.
    w_start = r_scl && w_scl_nxt && r_sda && !w_sda_nxt;
    w_stop  = r_scl && w_scl_nxt && !r_sda && w_sda_nxt;
  end

  // Filtered levels plus one-cycle edge and condition pulses. Disabling
  // forces the idle level and swallows any pulse the forced change implies.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_scl      <= 1'b1;
      r_sda      <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else if (!I_EN) begin
      r_scl      <= 1'b1;
      r_sda      <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl      <= w_scl_nxt;
      r_sda      <= w_sda_nxt;
      r_scl_rise <= !r_scl && w_scl_nxt;
      r_scl_fall <= r_scl && !w_scl_nxt;
      r_start    <= w_start;
      r_stop     <= w_stop;
    end
  end

  // Bus busy: set by START (repeated START keeps it set), cleared by STOP.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_busy <= 1'b0;
    end else if (!I_EN) begin
      r_busy <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
    end else if (w_stop) begin
      r_busy <= 1'b0;
    end
  end

  assign O_SCL      = r_scl;
  assign O_SDA      = r_sda;
  assign O_SCL_RISE = r_scl_rise;
  assign O_SCL_FALL = r_scl_fall;
  assign O_START    = r_start;
  assign O_STOP     = r_stop;
  assign O_BUSY     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bus_filter
// Description : Self-checking bench for i2c_bus_filter. A cycle-level
//               behavioural model tracks every output; a compare process
//               checks all outputs on each falling clock edge, and directed
//               scenarios pin latencies and glitch behaviour with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_filter;

  localparam int FD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] dfsr;
  logic       scl_pin;
  logic       sda_pin;
  logic       o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  // {scl, sda, rise, fall, start, stop, busy}
  logic [6:0] dut_vec;
  logic [6:0] exp_vec;

  i2c_bus_filter #(.FILT_DEPTH(FD)) dut (
    .I_CLK      (clk),
    .I_RST      (rst),
    .I_EN       (en),
    .I_I2CDFSRR (dfsr),
    .I_SCL_PIN  (scl_pin),
    .I_SDA_PIN  (sda_pin),
    .O_SCL      (o_scl),
    .O_SDA      (o_sda),
    .O_SCL_RISE (o_rise),
    .O_SCL_FALL (o_fall),
    .O_START    (o_start),
    .O_STOP     (o_stop),
    .O_BUSY     (o_busy)
  );

  assign dut_vec = {o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy};

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_pipe_scl[$];   // pin values still travelling through the synchroniser
  bit m_pipe_sda[$];
  bit m_win_scl[$];    // last FD samples taken, front = newest
  bit m_win_sda[$];
  int m_cnt;
  bit m_scl, m_sda, m_busy, m_rise, m_fall, m_start, m_stop;

  assign exp_vec = {m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy};

  function automatic void model_clear_windows();
    m_win_scl = {};
    m_win_sda = {};
    for (int i = 0; i < FD; i++) begin
      m_win_scl.push_back(1'b1);
      m_win_sda.push_back(1'b1);
    end
  endfunction

  function automatic void model_reset();
    m_pipe_scl = '{1'b1, 1'b1};
    m_pipe_sda = '{1'b1, 1'b1};
    model_clear_windows();
    m_cnt = 0;
    {m_scl, m_sda} = 2'b11;
    {m_busy, m_rise, m_fall, m_start, m_stop} = 5'b0;
  endfunction

  // Returns 1 or 0 if every sample in the window has that value, else -1.
  function automatic int window_level(input bit w[$]);
    int ones = 0;
    foreach (w[i]) ones += int'(w[i]);
    if (ones == w.size()) return 1;
    if (ones == 0) return 0;
    return -1;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit synced_scl, synced_sda, tick, n_scl, n_sda;
    int lv;
    if (rst) begin
      model_reset();
      return;
    end
    synced_scl = m_pipe_scl.pop_back();
    synced_sda = m_pipe_sda.pop_back();
    m_pipe_scl.push_front(scl_pin);
    m_pipe_sda.push_front(sda_pin);
    if (!en) begin
      m_cnt = 0;
      model_clear_windows();
      {m_scl, m_sda} = 2'b11;
      {m_busy, m_rise, m_fall, m_start, m_stop} = 5'b0;
      return;
    end
    tick = (m_cnt >= int'(dfsr % 64));
    m_cnt = tick ? 0 : m_cnt + 1;
    lv = window_level(m_win_scl);
    n_scl = (lv < 0) ? m_scl : (lv == 1);
    lv = window_level(m_win_sda);
    n_sda = (lv < 0) ? m_sda : (lv == 1);
    m_rise  = (m_scl == 1'b0) && (n_scl == 1'b1);
    m_fall  = (m_scl == 1'b1) && (n_scl == 1'b0);
    m_start = m_scl && n_scl && m_sda && !n_sda;
    m_stop  = m_scl && n_scl && !m_sda && n_sda;
    if (m_start) m_busy = 1'b1;
    else if (m_stop) m_busy = 1'b0;
    m_scl = n_scl;
    m_sda = n_sda;
    if (tick) begin
      m_win_scl.push_front(synced_scl);
      m_win_sda.push_front(synced_sda);
      void'(m_win_scl.pop_back());
      void'(m_win_sda.pop_back());
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin
        $display("FAIL model_compare t=%0t got scl,sda,rise,fall,start,stop,busy=%b expected %b",
                 $time, dut_vec, exp_vec);
      end else begin
        n_pass++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit         c_rst, c_en, c_scl, c_sda;
  logic [7:0] c_dfsr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // One clock with the current stimulus; the model follows the same edge.
  task automatic drive();
    @(negedge clk);
    #1;
    rst = c_rst; en = c_en; dfsr = c_dfsr; scl_pin = c_scl; sda_pin = c_sda;
    if (c_rst) model_reset();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive();
  endtask

  // Clocks until output bit idx equals val; -1 when the bound expires.
  task automatic wait_bit(input int idx, input bit val, input int max, output int cyc);
    int k = 0;
    bit hit = 1'b0;
    while (!hit && k < max) begin
      drive();
      k++;
      hit = (dut_vec[idx] === val);
    end
    cyc = hit ? k : -1;
  endtask

  // Clocks in a window during which output bit idx is high.
  task automatic count_high(input int idx, input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      drive();
      if (dut_vec[idx] === 1'b1) hits++;
    end
  endtask

  localparam int IX_SCL = 6, IX_SDA = 5, IX_RISE = 4, IX_FALL = 3;
  localparam int IX_START = 2, IX_STOP = 1, IX_BUSY = 0;

  initial begin
    int cyc, hits, hits2, len;
    int pick;
    rst = 1'b1; en = 1'b1; dfsr = 8'd0; scl_pin = 1'b1; sda_pin = 1'b1;
    c_rst = 1'b1; c_en = 1'b1; c_dfsr = 8'd0; c_scl = 1'b1; c_sda = 1'b1;
    model_reset();
    cmp_on = 1'b1;
    hold(2);
    c_rst = 1'b0;
    hold(10);

    // Reset while the pins are low, then watch the release latency.
    c_scl = 1'b0; c_sda = 1'b0;
    hold(20);
    c_rst = 1'b1;
    hold(2);
    chk("reset_state", int'(dut_vec), int'(7'b1100000));
    c_rst = 1'b0;
    wait_bit(IX_SCL, 1'b0, 20, cyc);
    chk("reset_release_latency", cyc, 6);
    chk("reset_release_sda", int'(o_sda), 0);

    // START then STOP.
    c_scl = 1'b1; c_sda = 1'b1;
    hold(10);
    c_sda = 1'b0;
    wait_bit(IX_START, 1'b1, 20, cyc);
    chk("start_latency", cyc, 6);
    chk("start_busy", int'(o_busy), 1);
    chk("start_sda_low", int'(o_sda), 0);
    drive();
    chk("start_one_cycle", int'(o_start), 0);
    hold(5);
    c_sda = 1'b1;
    wait_bit(IX_STOP, 1'b1, 20, cyc);
    chk("stop_latency", cyc, 6);
    chk("stop_busy_cleared", int'(o_busy), 0);
    hold(5);

    // Glitch rejection at DFSR=0.
    c_scl = 1'b0; hold(2); c_scl = 1'b1;
    count_high(IX_FALL, 15, hits);
    chk("glitch2_no_fall", hits, 0);
    c_scl = 1'b0; hold(3); c_scl = 1'b1;
    hits = 0; hits2 = 0; len = 0;
    for (int i = 0; i < 20; i++) begin
      drive();
      if (o_fall === 1'b1) hits++;
      if (o_rise === 1'b1) hits2++;
      if (o_scl === 1'b0) len++;
    end
    chk("glitch3_fall", hits, 1);
    chk("glitch3_rise", hits2, 1);
    chk("glitch3_low_width", len, 3);

    // Sampling rate DFSR=4 from a random tick phase.
    c_dfsr = 8'd4;
    hold(12 + $urandom_range(0, 4));
    c_scl = 1'b0;
    wait_bit(IX_FALL, 1'b1, 30, cyc);
    chk("dfsr4_fall_window", int'(cyc >= 14 && cyc <= 18), 1);
    c_scl = 1'b1;
    hold(30);
    c_scl = 1'b0; hold(10); c_scl = 1'b1;
    count_high(IX_FALL, 40, hits);
    chk("dfsr4_glitch10_rejected", hits, 0);
    c_dfsr = 8'hC0;   // upper bits ignored: behaves as DFSR=0
    hold(10);

    // Repeated START while busy.
    c_sda = 1'b0; hold(10);
    chk("busy_before_rstart", int'(o_busy), 1);
    c_scl = 1'b0; hold(8);
    c_sda = 1'b1; hold(8);
    c_scl = 1'b1; hold(8);
    c_sda = 1'b0;
    wait_bit(IX_START, 1'b1, 20, cyc);
    chk("rstart_latency", cyc, 6);
    chk("rstart_busy_kept", int'(o_busy), 1);
    c_sda = 1'b1; hold(10);

    // SCL and SDA fall together: SCL edge only.
    c_scl = 1'b0; c_sda = 1'b0;
    hits = 0; hits2 = 0;
    for (int i = 0; i < 12; i++) begin
      drive();
      if (o_start === 1'b1) hits++;
      if (o_fall === 1'b1) hits2++;
    end
    chk("simul_no_start", hits, 0);
    chk("simul_fall", hits2, 1);

    // Disable while busy with the pins low.
    c_scl = 1'b1; c_sda = 1'b1; hold(8);
    c_sda = 1'b0; hold(8);
    c_scl = 1'b0; hold(8);
    chk("disable_pre_busy", int'(o_busy), 1);
    c_en = 1'b0;
    drive();
    chk("disable_state", int'(dut_vec), int'(7'b1100000));
    hold(3);
    c_en = 1'b1;
    wait_bit(IX_FALL, 1'b1, 10, cyc);
    chk("reenable_fall", int'(cyc >= 1 && cyc <= 6), 1);
    chk("reenable_sda_low", int'(o_sda), 0);
    hold(5);

    // Randomised traffic, including rate changes, disables and resets.
    for (int it = 0; it < 2500; it++) begin
      pick = int'($urandom_range(0, 99));
      c_rst = (pick == 0);
      if (pick >= 1 && pick <= 3) c_en = ~c_en;
      else if (!c_en && pick < 30) c_en = 1'b1;
      if (pick >= 90) begin
        case ($urandom_range(0, 5))
          0, 1: c_dfsr = 8'd0;
          2:    c_dfsr = 8'd1;
          3:    c_dfsr = 8'd3;
          4:    c_dfsr = 8'(4 * $urandom_range(0, 2));
          default: c_dfsr = 8'($urandom_range(0, 255)) & 8'hC3;
        endcase
      end
      if ($urandom_range(0, 1) == 1) c_scl = ~c_scl;
      if ($urandom_range(0, 2) == 0) c_sda = ~c_sda;
      hold(int'($urandom_range(1, 12)));
      c_rst = 1'b0;
    end
    hold(4);

    cmp_on = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
